// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: PC, memory issue, delivery, redirect and link.
// Optional FETCH_SKID_EN adds a one-entry hold register for stalls.
module fetch_unit #(
    parameter logic [10:0] RESET_PC = 11'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        halt,
    input  logic        branch_control,
    input  logic [10:0] branch_pc,
    input  logic        write_reg,
    input  logic [31:0] imem_rdata,
    output logic [10:0] imem_addr,
    output logic        imem_en,
    output logic [31:0] instr,
    output logic [10:0] instr_pc,
    output logic        instr_valid,
    output logic [10:0] link_pc,
    output logic        link_valid
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]  state;
    logic [10:0] pc;
    logic        fl_valid;
    logic [10:0] fl_tag;
    logic        issue;
    logic        halt_entry;

    assign issue      = (state == RUN) & ~stall & ~branch_control & ~halt;
    assign halt_entry = (state == RUN) & halt;
    assign imem_en    = issue;
    assign imem_addr  = pc;

`ifdef FETCH_SKID_EN
    logic        hold_valid;
    logic [31:0] hold_word;
    logic [10:0] hold_tag;

    always_comb begin
        instr_valid = fl_valid | hold_valid;
        instr       = 32'd0;
        instr_pc    = 11'd0;
        if (hold_valid) begin
            instr    = hold_word;
            instr_pc = hold_tag;
        end else if (fl_valid) begin
            instr    = imem_rdata;
            instr_pc = fl_tag;
        end
    end

    // Park an unaccepted word so it stays visible for the whole stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_word  <= 32'd0;
            hold_tag   <= 11'd0;
        end else if (branch_control || halt_entry) begin
            hold_valid <= 1'b0;
        end else if (hold_valid) begin
            if (!stall)
                hold_valid <= 1'b0;
        end else if (fl_valid && stall) begin
            hold_valid <= 1'b1;
            hold_word  <= imem_rdata;
            hold_tag   <= fl_tag;
        end
    end
`else
    always_comb begin
        instr_valid = fl_valid;
        instr       = 32'd0;
        instr_pc    = 11'd0;
        if (fl_valid) begin
            instr    = imem_rdata;
            instr_pc = fl_tag;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            fl_valid <= 1'b0;
            fl_tag   <= 11'd0;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (halt) state <= HALT;
                default: state <= HALT;
            endcase

            fl_valid <= issue;
            if (issue)
                fl_tag <= pc;

            if (branch_control && state != HALT)
                pc <= branch_pc;
            else if (issue)
                pc <= pc + 11'd1;
`ifndef FETCH_SKID_EN
            // Without a hold register the unaccepted word is re-fetched.
            else if (stall && fl_valid && state == RUN)
                pc <= fl_tag;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            link_pc    <= 11'd0;
            link_valid <= 1'b0;
        end else begin
            link_valid <= branch_control & write_reg;
            if (branch_control && write_reg)
                link_pc <= instr_pc + 11'd1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: reset, streaming, redirect, link,
// stall (both build variants) and halt.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        halt;
    logic        branch_control;
    logic [10:0] branch_pc;
    logic        write_reg;

    logic [31:0] rdata_a, rdata_b;
    logic [10:0] addr_a, addr_b;
    logic        en_a, en_b;
    logic [31:0] instr_a, instr_b;
    logic [10:0] ipc_a, ipc_b;
    logic        iv_a, iv_b;
    logic [10:0] lpc_a, lpc_b;
    logic        lv_a, lv_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(11'd0)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt),
        .branch_control(branch_control), .branch_pc(branch_pc),
        .write_reg(write_reg), .imem_rdata(rdata_a),
        .imem_addr(addr_a), .imem_en(en_a), .instr(instr_a),
        .instr_pc(ipc_a), .instr_valid(iv_a),
        .link_pc(lpc_a), .link_valid(lv_a)
    );

    fetch_unit #(.RESET_PC(11'd2046)) u_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .halt(1'b0),
        .branch_control(1'b0), .branch_pc(11'd0),
        .write_reg(1'b0), .imem_rdata(rdata_b),
        .imem_addr(addr_b), .imem_en(en_b), .instr(instr_b),
        .instr_pc(ipc_b), .instr_valid(iv_b),
        .link_pc(lpc_b), .link_valid(lv_b)
    );

    // Synchronous memories: word = address + 100, garbage when not read.
    always_ff @(posedge clk) begin
        rdata_a <= en_a ? 32'(addr_a) + 32'd100 : 32'hdead_beef;
        rdata_b <= en_b ? 32'(addr_b) + 32'd100 : 32'hdead_beef;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk_word(input string tag, input logic [10:0] pc);
        check({tag, " valid"}, 32'(iv_a), 32'd1);
        check({tag, " pc"}, 32'(ipc_a), 32'(pc));
        check({tag, " instr"}, instr_a, 32'(pc) + 32'd100);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; halt = 1'b0;
        branch_control = 1'b0; branch_pc = 11'd0; write_reg = 1'b0;

        cyc(); settle();
        check("rst imem_en", 32'(en_a), 32'd0);
        check("rst instr_valid", 32'(iv_a), 32'd0);
        check("rst instr", instr_a, 32'd0);
        check("rst instr_pc", 32'(ipc_a), 32'd0);
        check("rst link_pc", 32'(lpc_a), 32'd0);
        check("rst link_valid", 32'(lv_a), 32'd0);
        check("rst imem_addr", 32'(addr_a), 32'd0);

        // Second reset edge; this cycle is BOOT.
        cyc(); rst = 1'b0; settle();
        check("boot imem_en", 32'(en_a), 32'd0);
        check("boot instr_valid", 32'(iv_a), 32'd0);

        cyc(); settle();
        check("first imem_en", 32'(en_a), 32'd1);
        check("first imem_addr", 32'(addr_a), 32'd0);
        check("first instr_valid", 32'(iv_a), 32'd0);
        check("wrap first addr", 32'(addr_b), 32'd2046);

        for (int k = 0; k < 5; k++) begin
            logic [10:0] wpc;
            cyc(); settle();
            chk_word("stream", 11'(k));
            wpc = 11'd2046 + 11'(k);
            check("wrap pc", 32'(ipc_b), 32'(wpc));
            check("wrap instr", instr_b, 32'(wpc) + 32'd100);
        end

        // Redirect with link at instr_pc = 5.
        cyc();
        branch_control = 1'b1; branch_pc = 11'd235; write_reg = 1'b1;
        settle();
        chk_word("pre-branch", 11'd5);
        check("branch imem_en", 32'(en_a), 32'd0);
        cyc();
        branch_control = 1'b0; write_reg = 1'b0;
        settle();
        check("bubble valid", 32'(iv_a), 32'd0);
        check("bubble addr", 32'(addr_a), 32'd235);
        check("link valid", 32'(lv_a), 32'd1);
        check("link pc", 32'(lpc_a), 32'd6);
        cyc(); settle();
        chk_word("target", 11'd235);
        check("link pulse end", 32'(lv_a), 32'd0);

        // write_reg alone must not link.
        cyc(); write_reg = 1'b1; settle();
        chk_word("stream2", 11'd236);
        cyc(); write_reg = 1'b0; settle();
        check("no link", 32'(lv_a), 32'd0);
        check("link kept", 32'(lpc_a), 32'd6);

        // Redirect to 8 to reach instr_pc = 10.
        branch_control = 1'b1; branch_pc = 11'd8;
        cyc(); branch_control = 1'b0; settle();
        cyc(); settle(); chk_word("s8", 11'd8);
        cyc(); settle(); chk_word("s9", 11'd9);

        // Stall three cycles at instr_pc = 10.
        cyc(); stall = 1'b1; settle();
        chk_word("stall0", 11'd10);
        check("stall0 en", 32'(en_a), 32'd0);
`ifdef FETCH_SKID_EN
        for (int k = 1; k < 3; k++) begin
            cyc(); settle();
            chk_word("hold", 11'd10);
            check("hold en", 32'(en_a), 32'd0);
        end
        cyc(); stall = 1'b0; settle();
        chk_word("release", 11'd10);
        check("release en", 32'(en_a), 32'd1);
        check("release addr", 32'(addr_a), 32'd11);
        cyc(); settle(); chk_word("after", 11'd11);
`else
        for (int k = 1; k < 3; k++) begin
            cyc(); settle();
            check("stall invalid", 32'(iv_a), 32'd0);
            check("rewind addr", 32'(addr_a), 32'd10);
        end
        cyc(); stall = 1'b0; settle();
        check("release bubble", 32'(iv_a), 32'd0);
        check("refetch en", 32'(en_a), 32'd1);
        check("refetch addr", 32'(addr_a), 32'd10);
        cyc(); settle(); chk_word("redeliver", 11'd10);
        cyc(); settle(); chk_word("after", 11'd11);
`endif

        // Redirect while stalled: target arrives two cycles later.
        cyc(); stall = 1'b1; settle();
        cyc(); branch_control = 1'b1; branch_pc = 11'd18; settle();
        cyc(); branch_control = 1'b0; stall = 1'b0; settle();
        check("stall-br bubble", 32'(iv_a), 32'd0);
        check("stall-br addr", 32'(addr_a), 32'd18);
        cyc(); settle(); chk_word("stall-br target", 11'd18);
        cyc(); settle(); chk_word("s19", 11'd19);

        // Halt at instr_pc = 20.
        cyc(); halt = 1'b1; settle();
        chk_word("halt cyc", 11'd20);
        check("halt en", 32'(en_a), 32'd0);
        cyc(); halt = 1'b0; settle();
        check("halted valid", 32'(iv_a), 32'd0);
        check("halted en", 32'(en_a), 32'd0);
        check("halted addr", 32'(addr_a), 32'd21);
        for (int k = 0; k < 3; k++) begin
            cyc(); settle();
            check("frozen en", 32'(en_a), 32'd0);
            check("frozen addr", 32'(addr_a), 32'd21);
            check("frozen valid", 32'(iv_a), 32'd0);
        end

        // Reset brings the unit back through BOOT.
        cyc(); rst = 1'b1; settle();
        cyc(); rst = 1'b0; settle();
        check("re-rst addr", 32'(addr_a), 32'd0);
        check("re-rst valid", 32'(iv_a), 32'd0);
        check("re-boot en", 32'(en_a), 32'd0);
        cyc(); settle();
        check("re-run en", 32'(en_a), 32'd1);
        cyc(); settle(); chk_word("re-first", 11'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
